// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA datapath blocks (parameter generator,
// Montgomery multiplier/exponentiator and the Montgomery exit converter).
//
// Contents:
//   DEFAULT_WIDTH   default operand width in bits (R = 2^DEFAULT_WIDTH)
//   SUB_W           width used by the shared final-subtract compare helper
//   state_t         IDLE/REDUCE/FIX/DONE sequencing states
//   final_sub_needed  decides whether the conditional final subtract of a
//                     Montgomery reduction must be taken (acc >= n)
package rsa_pkg;

  localparam int DEFAULT_WIDTH = 4096;

  // Wide enough for a WIDTH+1 bit accumulator of any width up to the default
  // plus one guard bit, so one compare helper serves every instance width.
  localparam int SUB_W = DEFAULT_WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    FIX    = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Callers zero-extend their accumulator and modulus to SUB_W. Because the
  // reduced accumulator is below 2*n, the subtract itself can then be done at
  // the native width: the true difference is below n and fits.
  function automatic logic final_sub_needed(input logic [SUB_W-1:0] acc,
                                            input logic [SUB_W-1:0] modulus);
    return acc >= modulus;
  endfunction

endpackage

// File: rtl/mont_exit_if.sv
// Handshake/data bundle for the Montgomery exit converter.
//
// Signals:
//   go    start request (level, sampled by the converter in IDLE/DONE)
//   x     Montgomery-domain operand
//   n     odd modulus
//   r     result x * 2^-WIDTH mod n, valid while done is high
//   done  result valid, held until the next accepted go or reset
//   busy  conversion in progress
//   err   (only when MONT_EXIT_CHECK_EN is defined) illegal operands seen
//
// Modports: master drives go/x/n, slave (the converter) drives the rest.
interface mont_exit_if
  import rsa_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             go;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] n;
  logic [WIDTH-1:0] r;
  logic             done;
  logic             busy;
`ifdef MONT_EXIT_CHECK_EN
  logic             err;

  modport master (output go, x, n, input r, done, busy, err);
  modport slave  (input go, x, n, output r, done, busy, err);
`else
  modport master (output go, x, n, input r, done, busy);
  modport slave  (input go, x, n, output r, done, busy);
`endif

endinterface

// File: rtl/mont_halve_step.sv
// One radix-2 Montgomery reduction step: acc -> (acc + acc[0]*n) / 2.
// Purely combinational so the loop in mont_exit can later be unrolled by
// chaining several of these per clock.
//
// Ports:
//   acc       WIDTH+1 bit accumulator (kept below 2*n by the caller)
//   n         WIDTH bit odd modulus
//   acc_next  WIDTH+1 bit halved accumulator
module mont_halve_step
  import rsa_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH:0]   acc_next
);

  logic [WIDTH+1:0] sum;

  // Adding the odd modulus to an odd accumulator makes the sum even, so the
  // shift is exact. The sum needs WIDTH+2 bits; after halving it fits again.
  always_comb begin
    sum      = {1'b0, acc} + ({(WIDTH+2){acc[0]}} & {2'b00, n});
    acc_next = (WIDTH+1)'(sum >> 1);
  end

endmodule

// File: rtl/mont_exit.sv
// Montgomery exit conversion: r = x * 2^-WIDTH mod n using WIDTH bit-serial
// radix-2 REDC iterations followed by one conditional subtract.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset (priority over go)
//   bus   mont_exit_if.slave: go/x/n in, r/done/busy (and err) out
//
// Build option: define MONT_EXIT_CHECK_EN to reject even/zero moduli and
// x >= n at go time; such requests finish at once with r=0 and err=1.
module mont_exit
  import rsa_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic      clk,
  input  logic      rst,
  mont_exit_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t           state, state_next;
  logic [WIDTH:0]   acc, acc_step;
  logic [WIDTH-1:0] n_q;
  logic [WIDTH-1:0] r_q;
  logic [CNT_W-1:0] cnt;
  logic             do_sub;
  logic             in_bad;

  mont_halve_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .n        (n_q),
    .acc_next (acc_step)
  );

  // Operand screening only exists in the checked build; otherwise every
  // request is taken as legal.
`ifdef MONT_EXIT_CHECK_EN
  logic err_q;
  assign in_bad  = ~bus.n[0] | (bus.x >= bus.n);
  assign bus.err = err_q;
`else
  assign in_bad  = 1'b0;
`endif

  assign do_sub = final_sub_needed({{(SUB_W-WIDTH-1){1'b0}}, acc},
                                   {{(SUB_W-WIDTH){1'b0}}, n_q});

  assign bus.r    = r_q;
  assign bus.done = (state == DONE);
  assign bus.busy = (state == REDUCE) || (state == FIX);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // A new request is accepted from IDLE or DONE; go is ignored while busy.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (bus.go) state_next = in_bad ? DONE : REDUCE;
      REDUCE:     if (cnt == LAST_ITER) state_next = FIX;
      FIX:        state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  // Operands are captured on acceptance so the requester may change x/n
  // while the conversion runs.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      n_q <= '0;
      r_q <= '0;
      cnt <= '0;
`ifdef MONT_EXIT_CHECK_EN
      err_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.go) begin
            acc <= {1'b0, bus.x};
            n_q <= bus.n;
            cnt <= '0;
            if (in_bad) r_q <= '0;
`ifdef MONT_EXIT_CHECK_EN
            err_q <= in_bad;
`endif
          end
        end
        REDUCE: begin
          acc <= acc_step;
          cnt <= cnt + CNT_W'(1);
        end
        FIX: begin
          r_q <= do_sub ? (acc[WIDTH-1:0] - n_q) : acc[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_exit.sv
// Self-checking bench for mont_exit: directed WIDTH=8 cases plus random
// WIDTH=64 operands against an independent modular-inverse model.
module tb_mont_exit;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mont_exit_if #(.WIDTH(8))  if8 ();
  mont_exit_if #(.WIDTH(64)) if64 ();

  mont_exit #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (if8)
  );

  mont_exit #(.WIDTH(64)) dut64 (
    .clk (clk),
    .rst (rst),
    .bus (if64)
  );

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  task automatic checkOutput(input string tag, input logic [63:0] got,
                             input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, expv);
    end
  endtask

  // x * inv(2)^w mod n, with inv(2) = (n+1)/2 for odd n.
  function automatic logic [63:0] refMont(input logic [63:0] xv,
                                          input logic [63:0] nv,
                                          input int w);
    logic [127:0] nn, inv2, p, res;
    nn   = {64'd0, nv};
    inv2 = (nn + 128'd1) >> 1;
    p    = 128'd1 % nn;
    for (int i = 0; i < w; i++) p = (p * inv2) % nn;
    res  = ({64'd0, xv} * p) % nn;
    return res[63:0];
  endfunction

  task automatic runOp8(input string tag, input logic [7:0] xv,
                        input logic [7:0] nv, input logic [7:0] ev,
                        input bit disturb);
    int lat;
    bit busy_ok;
    logic [63:0] e;
    @(negedge clk);
    if8.go = 1'b1;
    if8.x  = xv;
    if8.n  = nv;
    exp_q.push_back({56'd0, ev});
    @(posedge clk);
    #1;
    if8.go = 1'b0;
    if (disturb) begin
      if8.x = 8'h5a;
      if8.n = 8'h33;
    end
    checkOutput({tag, "_busy_start"}, {63'd0, if8.busy}, 64'd1);
    checkOutput({tag, "_done_drop"}, {63'd0, if8.done}, 64'd0);
    lat = 0;
    busy_ok = 1'b1;
    while (!if8.done && lat < 20) begin
      if8.go = (disturb && lat == 3);
      @(posedge clk);
      #1;
      lat++;
      if (!if8.done && !if8.busy) busy_ok = 1'b0;
      if (if8.done && if8.busy) busy_ok = 1'b0;
    end
    if8.go = 1'b0;
    checkOutput({tag, "_latency"}, 64'(lat), 64'd9);
    checkOutput({tag, "_busy"}, {63'd0, busy_ok}, 64'd1);
    e = exp_q.pop_front();
    checkOutput({tag, "_r"}, {56'd0, if8.r}, e);
`ifdef MONT_EXIT_CHECK_EN
    checkOutput({tag, "_err"}, {63'd0, if8.err}, 64'd0);
`endif
  endtask

  task automatic applyStimulus(input logic [63:0] xv, input logic [63:0] nv);
    int lat;
    logic [63:0] e;
    @(negedge clk);
    if64.go = 1'b1;
    if64.x  = xv;
    if64.n  = nv;
    exp_q.push_back(refMont(xv, nv, 64));
    @(posedge clk);
    #1;
    if64.go = 1'b0;
    lat = 0;
    while (!if64.done && lat < 80) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("w64_latency", 64'(lat), 64'd65);
    e = exp_q.pop_front();
    checkOutput("w64_r", if64.r, e);
  endtask

  initial begin
    rst     = 1'b1;
    if8.go  = 1'b0;
    if8.x   = '0;
    if8.n   = '0;
    if64.go = 1'b0;
    if64.x  = '0;
    if64.n  = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_done", {63'd0, if8.done}, 64'd0);
    checkOutput("reset_busy", {63'd0, if8.busy}, 64'd0);
    checkOutput("reset_r", {56'd0, if8.r}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    runOp8("n13_x9", 8'd9, 8'd13, 8'd1, 1'b0);
    runOp8("n13_x12", 8'd12, 8'd13, 8'd10, 1'b0);
    runOp8("n13_x0", 8'd0, 8'd13, 8'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkOutput("hold_done", {63'd0, if8.done}, 64'd1);
      checkOutput("hold_r", {56'd0, if8.r}, 64'd0);
    end
    runOp8("n13_x12_again", 8'd12, 8'd13, 8'd10, 1'b0);
    runOp8("n1_x0", 8'd0, 8'd1, 8'd0, 1'b0);
    runOp8("n255_x254_chg", 8'd254, 8'd255, 8'd254, 1'b1);
    runOp8("n13_x12_gopoke", 8'd12, 8'd13, 8'd10, 1'b1);

    // Abort a conversion partway through REDUCE.
    @(negedge clk);
    if8.go = 1'b1;
    if8.x  = 8'd254;
    if8.n  = 8'd255;
    @(posedge clk);
    #1;
    if8.go = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrst_done", {63'd0, if8.done}, 64'd0);
    checkOutput("midrst_busy", {63'd0, if8.busy}, 64'd0);
    checkOutput("midrst_r", {56'd0, if8.r}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    runOp8("after_rst_n13_x9", 8'd9, 8'd13, 8'd1, 1'b0);

`ifdef MONT_EXIT_CHECK_EN
    @(negedge clk);
    if8.go = 1'b1;
    if8.x  = 8'd3;
    if8.n  = 8'd12;
    @(posedge clk);
    #1;
    if8.go = 1'b0;
    checkOutput("chk_done", {63'd0, if8.done}, 64'd1);
    checkOutput("chk_busy", {63'd0, if8.busy}, 64'd0);
    checkOutput("chk_err", {63'd0, if8.err}, 64'd1);
    checkOutput("chk_r", {56'd0, if8.r}, 64'd0);
    runOp8("chk_recover", 8'd9, 8'd13, 8'd1, 1'b0);
`endif

    for (int i = 0; i < 200; i++) begin
      logic [63:0] nv, xv;
      nv = {$urandom, $urandom} | 64'd1;
      if (i == 0) nv = 64'hFFFF_FFFF_FFFF_FFFF;
      xv = {$urandom, $urandom} % nv;
      if (i == 0) xv = nv - 64'd1;
      applyStimulus(xv, nv);
    end

    checkOutput("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
